// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised circular-buffer FIFO with first-word-fall-through read, thresholds and sticky error flags.
module sync_fifo_param #(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     clr_err,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              push_ok, pop_ok;
  assign fifo_full    = count_q == CNT_W'(DEPTH);
  assign fifo_empty   = count_q == '0;
  assign almost_full  = count_q >= CNT_W'(AF_THRESH);
  assign almost_empty = count_q <= CNT_W'(AE_THRESH);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign data_out     = fifo_empty ? '0 : mem_q[rd_ptr_q];
  // a pop on a full FIFO frees the slot the simultaneous push lands in
  assign push_ok = push & (!fifo_full | pop);
  assign pop_ok  = pop & !fifo_empty;
  always_comb begin
    mem_d = mem_q;
    if (push_ok && !flush) mem_d[wr_ptr_q] = data_in;
    wr_ptr_d    = flush ? '0 : wr_ptr_q + ADDR_W'(push_ok);
    rd_ptr_d    = flush ? '0 : rd_ptr_q + ADDR_W'(pop_ok);
    count_d     = flush ? '0 : count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    overflow_d  = (overflow_q & !clr_err) | (push & fifo_full & !pop & !flush);
    underflow_d = (underflow_q & !clr_err) | (pop & fifo_empty & !flush);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: queue-based reference model with per-cycle comparison, directed scenarios and random traffic.
module tb_sync_fifo_param;
  localparam int DATA_W = 4, DEPTH = 4, AF = 3, AE = 1;
  logic clk = 0, reset = 1, push = 0, pop = 0, flush = 0, clr_err = 0;
  logic [DATA_W-1:0] data_in = '0, data_out;
  logic fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;
  int checks = 0, errors = 0;
  logic [DATA_W-1:0] q[$];
  bit m_ov = 0, m_un = 0;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush), .clr_err(clr_err),
    .data_in(data_in), .data_out(data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // reference model: a queue of words plus two sticky bits
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete(); m_ov = 0; m_un = 0;
    end else begin
      bit full, empty;
      full = q.size() == DEPTH;
      empty = q.size() == 0;
      if (clr_err) begin m_ov = 0; m_un = 0; end
      if (flush) q.delete();
      else begin
        if (push && full && !pop) m_ov = 1;
        if (pop && empty) m_un = 1;
        if (pop && !empty) void'(q.pop_front());
        if (push && (!full || pop)) q.push_back(data_in);
      end
    end
  end

  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("fifo_empty", 32'(fifo_empty), 32'(n == 0));
    chk("fifo_full", 32'(fifo_full), 32'(n == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("data_out", 32'(data_out), n == 0 ? 32'd0 : 32'(q[0]));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_un));
  end

  task automatic cyc(input bit p, input bit po, input bit f, input bit c, input logic [DATA_W-1:0] d);
    push = p; pop = po; flush = f; clr_err = c; data_in = d;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_err", 32'({overflow, underflow}), 0);
    cyc(1, 0, 0, 0, 4'hA);
    chk("fill1_dout", 32'(data_out), 32'hA);
    chk("fill1_count", 32'(count), 1);
    cyc(1, 0, 0, 0, 4'hB);
    cyc(1, 0, 0, 0, 4'hC);
    chk("fill3_af", 32'(almost_full), 1);
    chk("fill3_full", 32'(fifo_full), 0);
    cyc(1, 0, 0, 0, 4'hD);
    chk("fill4_full", 32'(fifo_full), 1);
    cyc(1, 0, 0, 0, 4'hE);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_dout", 32'(data_out), 32'hA);
    cyc(1, 1, 0, 0, 4'hE);
    chk("fullpp_count", 32'(count), 4);
    chk("fullpp_dout", 32'(data_out), 32'hB);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("wrap_dout", 32'(data_out), 32'hE);
    cyc(0, 1, 0, 0, 0);
    chk("drain_empty", 32'(fifo_empty), 1);
    chk("drain_dout", 32'(data_out), 0);
    cyc(0, 0, 0, 1, 0);
    chk("clr_ovf", 32'(overflow), 0);
    cyc(1, 1, 0, 0, 4'h5);
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_count", 32'(count), 1);
    chk("unf_dout", 32'(data_out), 32'h5);
    cyc(0, 0, 0, 1, 0);
    chk("clr_unf", 32'(underflow), 0);
    cyc(1, 0, 0, 0, 4'h1);
    cyc(1, 0, 0, 0, 4'h2);
    chk("preflush_count", 32'(count), 3);
    cyc(1, 0, 1, 0, 4'h7);
    chk("flush_count", 32'(count), 0);
    chk("flush_dout", 32'(data_out), 0);
    chk("flush_err", 32'({overflow, underflow}), 0);
    cyc(1, 0, 0, 0, 4'h7);
    chk("postflush_dout", 32'(data_out), 32'h7);
    cyc(1, 0, 0, 0, 4'h8);
    cyc(0, 0, 0, 0, 0);
    #1 reset = 1;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_empty", 32'(fifo_empty), 1);
    @(posedge clk); #1 reset = 0;
    cyc(1, 0, 0, 0, 4'h3);
    chk("resume_dout", 32'(data_out), 32'h3);
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
          1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 5), 4'($urandom));
    cyc(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
